gf180mcu_fd_sc_mcu9t5v0__norn_pipe: RTL and testbench

GF180MCU_FD_SC_MCU9T5V0__NORN_PIPE -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__norn_pipe

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__pkg.sv | 22 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__norn_pipe_if.sv | 26 ++
 rtl/gf180mcu_fd_sc_mcu9t5v0__pipe_stage.sv | 35 +++
 rtl/gf180mcu_fd_sc_mcu9t5v0__norn_pipe.sv | 91 +++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__norn_pipe.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pkg.sv
// Shared definitions for the NOR/OR reduction pipeline: parameter limits,
// the reduction mode encoding and a two-input NOR reference function.
package gf180mcu_fd_sc_mcu9t5v0__pkg;

  // Legal parameter ranges
  localparam int N_IN_MIN = 2;
  localparam int N_IN_MAX = 8;
  localparam int CH_MIN   = 1;
  localparam int CH_MAX   = 8;

  // Reduction mode, selected through the INVERT parameter
  typedef enum logic {
    MODE_OR  = 1'b0,
    MODE_NOR = 1'b1
  } mode_e;

  // Behavioural model of the two-input NOR cell
  function automatic logic nor2(input logic a, input logic b);
    return ~(a | b);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__norn_pipe_if.sv
// Operand/result handshake bundle of the reduction pipeline.
// master = producer/consumer side (drives operands and result ready),
// slave  = the pipeline itself.
interface gf180mcu_fd_sc_mcu9t5v0__norn_pipe_if #(
  parameter int N_IN  = 2,
  parameter int CH    = 1,
  parameter int CNT_W = 8
);
  logic [N_IN*CH-1:0] a;
  logic               a_valid;
  logic               a_ready;
  logic [CH-1:0]      zn;
  logic               zn_valid;
  logic               zn_ready;
  logic [CNT_W-1:0]   count;

  modport master (
    output a, a_valid, zn_ready,
    input  a_ready, zn, zn_valid, count
  );

  modport slave (
    input  a, a_valid, zn_ready,
    output a_ready, zn, zn_valid, count
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pipe_stage.sv
// One valid/ready register slice. Accepts new data whenever it is empty or
// its current contents leave on the same edge, so a chain of these sustains
// one transfer per cycle without a skid buffer.
module gf180mcu_fd_sc_mcu9t5v0__pipe_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign o_ready = !r_valid || i_ready;
  assign w_load  = i_valid && o_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Occupancy and payload register; reset drops any held item
  always_ff @(posedge clk) begin
    if (srst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (o_ready) r_valid <= i_valid;
      if (w_load)  r_data  <= i_data;
    end
  end
endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__norn_pipe.sv
// Two-stage pipelined per-channel N-input NOR (or OR) with valid/ready flow
// control and a delivered-result counter. S1 holds the raw operand, S2 holds
// the reduced result driven on ZN.
module gf180mcu_fd_sc_mcu9t5v0__norn_pipe
  import gf180mcu_fd_sc_mcu9t5v0__pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int CH     = 1,
  parameter int INVERT = 1,
  parameter int CNT_W  = 8
) (
`ifdef USE_POWER_PINS
  inout  wire                VDD,
  inout  wire                VSS,
`endif
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_IN*CH-1:0] A,
  input  logic               A_VALID,
  output logic               A_READY,
  output logic [CH-1:0]      ZN,
  output logic               ZN_VALID,
  input  logic               ZN_READY,
  output logic [CNT_W-1:0]   COUNT
);
  // Reject illegal configurations at elaboration
  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("N_IN out of range");
  end
  if (CH < CH_MIN || CH > CH_MAX) begin : g_bad_ch
    $error("CH out of range");
  end
  if (INVERT != int'(MODE_OR) && INVERT != int'(MODE_NOR)) begin : g_bad_invert
    $error("INVERT must be 0 or 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  logic               w_s1_valid;
  logic [N_IN*CH-1:0] w_s1_data;
  logic               w_s2_ready;
  logic [CH-1:0]      w_red;
  logic [CNT_W-1:0]   r_count;

  // Operand stage
  gf180mcu_fd_sc_mcu9t5v0__pipe_stage #(.W(N_IN*CH)) u_s1 (
    .clk     (CLK),
    .srst    (RST),
    .i_valid (A_VALID),
    .o_ready (A_READY),
    .i_data  (A),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_data)
  );

  // Per-channel reduction between the stages
  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic w_any;
    assign w_any = |w_s1_data[gi*N_IN +: N_IN];
    if (INVERT == int'(MODE_NOR)) begin : g_nor
      assign w_red[gi] = nor2(w_any, 1'b0);
    end else begin : g_or
      assign w_red[gi] = w_any;
    end
  end

  // Result stage
  gf180mcu_fd_sc_mcu9t5v0__pipe_stage #(.W(CH)) u_s2 (
    .clk     (CLK),
    .srst    (RST),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  (w_red),
    .o_valid (ZN_VALID),
    .i_ready (ZN_READY),
    .o_data  (ZN)
  );

  // Count delivered results, wrapping naturally at the counter width
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
    end else if (ZN_VALID && ZN_READY) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign COUNT = r_count;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__norn_pipe.sv
// Directed self-checking bench for the NOR/OR reduction pipeline.
module tb_gf180mcu_fd_sc_mcu9t5v0__norn_pipe;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

`ifdef USE_POWER_PINS
  wire vdd = 1'b1;
  wire vss = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // if0: default config, if1/if2: 4x2 NOR/OR, if3: 2-bit counter
  gf180mcu_fd_sc_mcu9t5v0__norn_pipe_if #(.N_IN(2), .CH(1), .CNT_W(8)) if0 ();
  gf180mcu_fd_sc_mcu9t5v0__norn_pipe_if #(.N_IN(4), .CH(2), .CNT_W(8)) if1 ();
  gf180mcu_fd_sc_mcu9t5v0__norn_pipe_if #(.N_IN(4), .CH(2), .CNT_W(8)) if2 ();
  gf180mcu_fd_sc_mcu9t5v0__norn_pipe_if #(.N_IN(2), .CH(1), .CNT_W(2)) if3 ();

  gf180mcu_fd_sc_mcu9t5v0__norn_pipe #(.N_IN(2), .CH(1), .INVERT(1), .CNT_W(8)) u_dut0 (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(clk), .RST(rst), .A(if0.a), .A_VALID(if0.a_valid), .A_READY(if0.a_ready),
    .ZN(if0.zn), .ZN_VALID(if0.zn_valid), .ZN_READY(if0.zn_ready), .COUNT(if0.count)
  );

  gf180mcu_fd_sc_mcu9t5v0__norn_pipe #(.N_IN(4), .CH(2), .INVERT(1), .CNT_W(8)) u_dut1 (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(clk), .RST(rst), .A(if1.a), .A_VALID(if1.a_valid), .A_READY(if1.a_ready),
    .ZN(if1.zn), .ZN_VALID(if1.zn_valid), .ZN_READY(if1.zn_ready), .COUNT(if1.count)
  );

  gf180mcu_fd_sc_mcu9t5v0__norn_pipe #(.N_IN(4), .CH(2), .INVERT(0), .CNT_W(8)) u_dut2 (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(clk), .RST(rst), .A(if2.a), .A_VALID(if2.a_valid), .A_READY(if2.a_ready),
    .ZN(if2.zn), .ZN_VALID(if2.zn_valid), .ZN_READY(if2.zn_ready), .COUNT(if2.count)
  );

  gf180mcu_fd_sc_mcu9t5v0__norn_pipe #(.N_IN(2), .CH(1), .INVERT(1), .CNT_W(2)) u_dut3 (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(clk), .RST(rst), .A(if3.a), .A_VALID(if3.a_valid), .A_READY(if3.a_ready),
    .ZN(if3.zn), .ZN_VALID(if3.zn_valid), .ZN_READY(if3.zn_ready), .COUNT(if3.count)
  );

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if0.a_valid = 1'b1; if0.a = 2'b11; if0.zn_ready = 1'b1;
    if1.a_valid = 1'b0; if1.a = '0;    if1.zn_ready = 1'b1;
    if2.a_valid = 1'b0; if2.a = '0;    if2.zn_ready = 1'b1;
    if3.a_valid = 1'b0; if3.a = '0;    if3.zn_ready = 1'b1;
    step();
    step();
    total_cnt++; if (if0.zn_valid !== 1'b0) $display("FAIL reset_zn_valid: got %b want 0", if0.zn_valid); else pass_cnt++;
    total_cnt++; if (if0.zn !== 1'b0) $display("FAIL reset_zn: got %b want 0", if0.zn); else pass_cnt++;
    total_cnt++; if (if0.count !== 8'd0) $display("FAIL reset_count: got %0d want 0", if0.count); else pass_cnt++;
    total_cnt++; if (if0.a_ready !== 1'b1) $display("FAIL reset_a_ready: got %b want 1", if0.a_ready); else pass_cnt++;
    total_cnt++; if (if1.zn !== 2'b00) $display("FAIL reset_zn_mc: got %b want 00", if1.zn); else pass_cnt++;
    rst = 1'b0;
    if0.a_valid = 1'b0;
    #1;
    total_cnt++; if (if0.a_ready !== 1'b1) $display("FAIL post_reset_a_ready: got %b want 1", if0.a_ready); else pass_cnt++;
    step();
  endtask

  task automatic test_streaming();
    logic [1:0] vec [4];
    logic       exp_zn [4];
    vec = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp_zn = '{1'b1, 1'b0, 1'b0, 1'b0};
    if0.zn_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if0.a_valid = (i < 4);
      if0.a = (i < 4) ? vec[i] : 2'b00;
      step();
      if (i >= 1 && i <= 4) begin
        $display("stream: A=%b ZN=%b COUNT=%0d", vec[i-1], if0.zn, if0.count);
        total_cnt++; if (if0.zn_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i-1, if0.zn_valid); else pass_cnt++;
        total_cnt++; if (if0.zn !== exp_zn[i-1]) $display("FAIL stream_zn[%0d]: got %b want %b", i-1, if0.zn, exp_zn[i-1]); else pass_cnt++;
        total_cnt++; if (if0.count !== 8'(i-1)) $display("FAIL stream_count[%0d]: got %0d want %0d", i-1, if0.count, i-1); else pass_cnt++;
      end
    end
    total_cnt++; if (if0.count !== 8'd4) $display("FAIL stream_final_count: got %0d want 4", if0.count); else pass_cnt++;
    total_cnt++; if (if0.zn_valid !== 1'b0) $display("FAIL stream_drain_valid: got %b want 0", if0.zn_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    // Operands 00, 01, 00 -> results 1, 0, 1; COUNT starts at 4
    if0.zn_ready = 1'b0;
    if0.a_valid = 1'b1; if0.a = 2'b00;
    step();
    if0.a = 2'b01;
    #1;
    total_cnt++; if (if0.a_ready !== 1'b1) $display("FAIL bp_ready_second: got %b want 1", if0.a_ready); else pass_cnt++;
    step();
    if0.a = 2'b00;
    #1;
    total_cnt++; if (if0.a_ready !== 1'b0) $display("FAIL bp_ready_full: got %b want 0", if0.a_ready); else pass_cnt++;
    step();
    step();
    total_cnt++; if (if0.zn !== 1'b1) $display("FAIL bp_hold_zn: got %b want 1", if0.zn); else pass_cnt++;
    total_cnt++; if (if0.zn_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b want 1", if0.zn_valid); else pass_cnt++;
    total_cnt++; if (if0.count !== 8'd4) $display("FAIL bp_hold_count: got %0d want 4", if0.count); else pass_cnt++;
    total_cnt++; if (if0.a_ready !== 1'b0) $display("FAIL bp_hold_ready: got %b want 0", if0.a_ready); else pass_cnt++;
    if0.zn_ready = 1'b1;
    #1;
    total_cnt++; if (if0.a_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", if0.a_ready); else pass_cnt++;
    step();
    if0.a_valid = 1'b0;
    $display("bp: delivered result 1, ZN=%b COUNT=%0d", if0.zn, if0.count);
    total_cnt++; if (if0.zn !== 1'b0) $display("FAIL bp_second_zn: got %b want 0", if0.zn); else pass_cnt++;
    total_cnt++; if (if0.count !== 8'd5) $display("FAIL bp_count5: got %0d want 5", if0.count); else pass_cnt++;
    step();
    total_cnt++; if (if0.zn !== 1'b1) $display("FAIL bp_third_zn: got %b want 1", if0.zn); else pass_cnt++;
    total_cnt++; if (if0.count !== 8'd6) $display("FAIL bp_count6: got %0d want 6", if0.count); else pass_cnt++;
    step();
    total_cnt++; if (if0.zn_valid !== 1'b0) $display("FAIL bp_drain_valid: got %b want 0", if0.zn_valid); else pass_cnt++;
    total_cnt++; if (if0.count !== 8'd7) $display("FAIL bp_count7: got %0d want 7", if0.count); else pass_cnt++;
  endtask

  task automatic test_multichannel();
    logic [7:0] vec [4];
    logic [1:0] exp_nor [4];
    logic [1:0] exp_or [4];
    vec     = '{8'h0F, 8'h00, 8'h81, 8'h10};
    exp_nor = '{2'b10, 2'b11, 2'b00, 2'b01};
    exp_or  = '{2'b01, 2'b00, 2'b11, 2'b10};
    for (int i = 0; i < 5; i++) begin
      if1.a_valid = (i < 4); if2.a_valid = (i < 4);
      if1.a = (i < 4) ? vec[i] : 8'h00;
      if2.a = (i < 4) ? vec[i] : 8'h00;
      step();
      if (i >= 1) begin
        $display("mc: A=%h NOR=%b OR=%b", vec[i-1], if1.zn, if2.zn);
        total_cnt++; if (if1.zn !== exp_nor[i-1]) $display("FAIL mc_nor[%0d]: got %b want %b", i-1, if1.zn, exp_nor[i-1]); else pass_cnt++;
        total_cnt++; if (if2.zn !== exp_or[i-1]) $display("FAIL mc_or[%0d]: got %b want %b", i-1, if2.zn, exp_or[i-1]); else pass_cnt++;
        total_cnt++; if (if1.zn_valid !== 1'b1) $display("FAIL mc_valid[%0d]: got %b want 1", i-1, if1.zn_valid); else pass_cnt++;
      end
    end
    step();
  endtask

  task automatic test_wrap();
    int exp_cnt;
    if3.zn_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if3.a_valid = (i < 5);
      if3.a = 2'(i);
      step();
      if (i >= 2) begin
        exp_cnt = (i - 1) % 4;
        $display("wrap: COUNT=%0d", if3.count);
        total_cnt++; if (if3.count !== 2'(exp_cnt)) $display("FAIL wrap_count[%0d]: got %0d want %0d", i-2, if3.count, exp_cnt); else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    if0.zn_ready = 1'b0;
    if0.a_valid = 1'b1; if0.a = 2'b00;
    step();
    if0.a = 2'b01;
    step();
    if0.a_valid = 1'b0;
    #1;
    total_cnt++; if (if0.zn_valid !== 1'b1) $display("FAIL rm_full_valid: got %b want 1", if0.zn_valid); else pass_cnt++;
    total_cnt++; if (if0.a_ready !== 1'b0) $display("FAIL rm_full_ready: got %b want 0", if0.a_ready); else pass_cnt++;
    rst = 1'b1;
    step();
    total_cnt++; if (if0.zn_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", if0.zn_valid); else pass_cnt++;
    total_cnt++; if (if0.count !== 8'd0) $display("FAIL rm_count: got %0d want 0", if0.count); else pass_cnt++;
    total_cnt++; if (if0.a_ready !== 1'b1) $display("FAIL rm_ready_in_reset: got %b want 1", if0.a_ready); else pass_cnt++;
    rst = 1'b0;
    if0.zn_ready = 1'b1;
    #1;
    total_cnt++; if (if0.a_ready !== 1'b1) $display("FAIL rm_ready_after: got %b want 1", if0.a_ready); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (if0.zn_valid !== 1'b0) $display("FAIL rm_stale[%0d]: got %b want 0", i, if0.zn_valid); else pass_cnt++;
      total_cnt++; if (if0.count !== 8'd0) $display("FAIL rm_stale_count[%0d]: got %0d want 0", i, if0.count); else pass_cnt++;
    end
  endtask

  task automatic test_idle_gaps();
    if0.zn_ready = 1'b1;
    if0.a_valid = 1'b1; if0.a = 2'b11;
    step();
    if0.a_valid = 1'b0;
    step();
    total_cnt++; if (if0.zn_valid !== 1'b1) $display("FAIL gap_first_valid: got %b want 1", if0.zn_valid); else pass_cnt++;
    total_cnt++; if (if0.zn !== 1'b0) $display("FAIL gap_first_zn: got %b want 0", if0.zn); else pass_cnt++;
    if0.a_valid = 1'b1; if0.a = 2'b00;
    step();
    if0.a_valid = 1'b0;
    total_cnt++; if (if0.zn_valid !== 1'b0) $display("FAIL gap_cycle_valid: got %b want 0", if0.zn_valid); else pass_cnt++;
    total_cnt++; if (if0.count !== 8'd1) $display("FAIL gap_count1: got %0d want 1", if0.count); else pass_cnt++;
    step();
    total_cnt++; if (if0.zn_valid !== 1'b1) $display("FAIL gap_second_valid: got %b want 1", if0.zn_valid); else pass_cnt++;
    total_cnt++; if (if0.zn !== 1'b1) $display("FAIL gap_second_zn: got %b want 1", if0.zn); else pass_cnt++;
    step();
    step();
    total_cnt++; if (if0.count !== 8'd2) $display("FAIL gap_total: got %0d want 2", if0.count); else pass_cnt++;
    total_cnt++; if (if0.zn_valid !== 1'b0) $display("FAIL gap_drain_valid: got %b want 0", if0.zn_valid); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_multichannel();
    test_wrap();
    test_reset_midstream();
    test_idle_gaps();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
